pipeline_sequencer: RTL and testbench



---
 rtl/pipeline_sequencer_if.sv | 39 +++
 rtl/pipeline_sequencer.sv | 145 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Run-control / hazard bundle between the debug+datapath side and the
// pipeline sequencer. The sequencer is the slave: it samples i_* and drives o_*.
interface pipeline_sequencer_if #(
   parameter int NB_ADDR = 5,
   parameter int NB_CNT  = 32
);
   logic               i_start;
   logic               i_step;
   logic               i_halt_req;
   logic               i_halt_instr;
   logic               i_jump;
   logic [NB_ADDR-1:0] i_id_rs;
   logic [NB_ADDR-1:0] i_id_rt;
   logic [NB_ADDR-1:0] i_ex_rt;
   logic               i_ex_memRead;
   logic               o_pipe_en;
   logic               o_pc_en;
   logic               o_ifid_en;
   logic               o_ifid_flush;
   logic               o_id_stall;
   logic [2:0]         o_state;
   logic               o_done;
   logic [NB_CNT-1:0]  o_cycle_count;
   logic [NB_CNT-1:0]  o_stall_count;

   modport master (
      output i_start, i_step, i_halt_req, i_halt_instr, i_jump,
             i_id_rs, i_id_rt, i_ex_rt, i_ex_memRead,
      input  o_pipe_en, o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall,
             o_state, o_done, o_cycle_count, o_stall_count
   );

   modport slave (
      input  i_start, i_step, i_halt_req, i_halt_instr, i_jump,
             i_id_rs, i_id_rt, i_ex_rt, i_ex_memRead,
      output o_pipe_en, o_pc_en, o_ifid_en, o_ifid_flush, o_id_stall,
             o_state, o_done, o_cycle_count, o_stall_count
   );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run-control and load-use/jump hazard sequencer for the 5-stage MIPS pipeline.
// Optional macro PIPE_SEQ_STALL_CNT_EN builds the saturating load-use stall counter.
module pipeline_sequencer #(
   parameter int NB_ADDR      = 5,
   parameter int NB_CNT       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 i_rst,
   pipeline_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int NB_DRN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
   localparam logic [NB_DRN-1:0] DRN_LAST = NB_DRN'(DRAIN_CYCLES - 1);

   function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
      return (&v) ? v : v + NB_CNT'(1);
   endfunction

   state_t              state_p0;
   logic [NB_DRN-1:0]   drain_cnt_p0;
   logic [NB_CNT-1:0]   cycle_cnt_p0;

   logic load_use;
   logic active;
   logic pipe_en;
   logic pc_en;
   logic ifid_en;
   logic ifid_flush;
   logic id_stall;
   logic done;

   assign load_use = bus.i_ex_memRead && (bus.i_ex_rt != '0) &&
                     ((bus.i_ex_rt == bus.i_id_rs) || (bus.i_ex_rt == bus.i_id_rt));
   assign active   = (state_p0 == ST_RUN) || (state_p0 == ST_STEP);

   // Stage p0 boundary: combinational control from current state and hazards
   always_comb begin
      pipe_en    = 1'b0;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      id_stall   = 1'b0;
      done       = 1'b0;
      case (state_p0)
         ST_RUN, ST_STEP: begin
            pipe_en = 1'b1;
            // A load-use bubble holds IF/ID, so jump/halt are re-seen next cycle
            if (load_use) begin
               id_stall = 1'b1;
            end else begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               ifid_flush = bus.i_jump;
            end
         end
         ST_DRAIN: begin
            pipe_en  = 1'b1;
            id_stall = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_p0     <= ST_IDLE;
         drain_cnt_p0 <= '0;
      end else begin
         case (state_p0)
            ST_IDLE: begin
               if (bus.i_start)     state_p0 <= ST_RUN;
               else if (bus.i_step) state_p0 <= ST_STEP;
            end
            ST_RUN: begin
               if (bus.i_halt_instr && !load_use) begin
                  state_p0     <= ST_DRAIN;
                  drain_cnt_p0 <= '0;
               end else if (bus.i_halt_req) begin
                  state_p0 <= ST_IDLE;
               end
            end
            ST_STEP: begin
               if (bus.i_halt_instr && !load_use) begin
                  state_p0     <= ST_DRAIN;
                  drain_cnt_p0 <= '0;
               end else begin
                  state_p0 <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               // HALT was caught in ID; let the older instructions retire through WB
               if (drain_cnt_p0 == DRN_LAST) state_p0 <= ST_DONE;
               else                          drain_cnt_p0 <= drain_cnt_p0 + NB_DRN'(1);
            end
            ST_DONE: begin
               state_p0 <= ST_DONE;
            end
            default: begin
               state_p0 <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst)        cycle_cnt_p0 <= '0;
      else if (pipe_en) cycle_cnt_p0 <= sat_inc(cycle_cnt_p0);
   end

`ifdef PIPE_SEQ_STALL_CNT_EN
   logic [NB_CNT-1:0] stall_cnt_p0;

   always_ff @(posedge clk) begin
      if (i_rst)                    stall_cnt_p0 <= '0;
      else if (active && load_use)  stall_cnt_p0 <= sat_inc(stall_cnt_p0);
   end

   assign bus.o_stall_count = stall_cnt_p0;
`else
   assign bus.o_stall_count = '0;
`endif

   assign bus.o_pipe_en     = pipe_en;
   assign bus.o_pc_en       = pc_en;
   assign bus.o_ifid_en     = ifid_en;
   assign bus.o_ifid_flush  = ifid_flush;
   assign bus.o_id_stall    = id_stall;
   assign bus.o_done        = done;
   assign bus.o_state       = state_p0;
   assign bus.o_cycle_count = cycle_cnt_p0;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed scoreboard bench for pipeline_sequencer: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pipeline_sequencer;

   localparam int NB_ADDR = 5;
   localparam int NB_CNT  = 32;

`ifdef PIPE_SEQ_STALL_CNT_EN
   localparam bit SC_ON = 1'b1;
`else
   localparam bit SC_ON = 1'b0;
`endif

   // {pipe_en, pc_en, ifid_en, ifid_flush, id_stall, done}
   localparam logic [5:0] C_OFF   = 6'b000000;
   localparam logic [5:0] C_RUN   = 6'b111000;
   localparam logic [5:0] C_JUMP  = 6'b111100;
   localparam logic [5:0] C_STALL = 6'b100010;
   localparam logic [5:0] C_DRAIN = 6'b100010;
   localparam logic [5:0] C_DONE  = 6'b000001;

   localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                          S_DRAIN = 3'd3, S_DONE = 3'd4;

   typedef struct {
      string             name;
      logic [2:0]        st;
      logic [5:0]        ctl;
      logic [NB_CNT-1:0] cc;
      logic [NB_CNT-1:0] sc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   pipeline_sequencer_if #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) bus();

   pipeline_sequencer #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT), .DRAIN_CYCLES(4)) dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [5:0] ctl;
         e   = exp_q.pop_front();
         ctl = {bus.o_pipe_en, bus.o_pc_en, bus.o_ifid_en,
                bus.o_ifid_flush, bus.o_id_stall, bus.o_done};
         checks = checks + 4;
         if (bus.o_state !== e.st) begin
            failures++;
            $display("FAIL %s state: got %0d want %0d", e.name, bus.o_state, e.st);
         end
         if (ctl !== e.ctl) begin
            failures++;
            $display("FAIL %s ctl{pipe,pc,ifid,flush,stall,done}: got %b want %b", e.name, ctl, e.ctl);
         end
         if (bus.o_cycle_count !== e.cc) begin
            failures++;
            $display("FAIL %s cycle_count: got %0d want %0d", e.name, bus.o_cycle_count, e.cc);
         end
         if (bus.o_stall_count !== e.sc) begin
            failures++;
            $display("FAIL %s stall_count: got %0d want %0d", e.name, bus.o_stall_count, e.sc);
         end
      end
   end

   task automatic cyc(input string nm, input logic [2:0] st, input logic [5:0] ctl,
                      input int cc, input int sc);
      exp_t e;
      e.name = nm;
      e.st   = st;
      e.ctl  = ctl;
      e.cc   = NB_CNT'(cc);
      e.sc   = SC_ON ? NB_CNT'(sc) : '0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic hz(input logic mr, input int ex_rt, input int rs, input int rt);
      bus.i_ex_memRead = mr;
      bus.i_ex_rt      = NB_ADDR'(ex_rt);
      bus.i_id_rs      = NB_ADDR'(rs);
      bus.i_id_rt      = NB_ADDR'(rt);
   endtask

   initial begin
      bus.i_start = 1'b0; bus.i_step = 1'b0; bus.i_halt_req = 1'b0;
      bus.i_halt_instr = 1'b0; bus.i_jump = 1'b0;
      hz(1'b0, 3, 1, 2);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      cyc("reset_idle", S_IDLE, C_OFF, 0, 0);
      bus.i_start = 1'b1;
      cyc("start_in_idle", S_IDLE, C_OFF, 0, 0);
      bus.i_start = 1'b0;
      cyc("run_first", S_RUN, C_RUN, 0, 0);
      hz(1'b1, 5, 5, 2);
      cyc("loaduse_rs", S_RUN, C_STALL, 1, 0);
      hz(1'b1, 0, 0, 2);
      cyc("exrt_zero_nostall", S_RUN, C_RUN, 2, 1);
      hz(1'b1, 5, 5, 2); bus.i_jump = 1'b1;
      cyc("jump_with_loaduse", S_RUN, C_STALL, 3, 1);
      hz(1'b0, 5, 5, 2);
      cyc("jump_only", S_RUN, C_JUMP, 4, 2);
      bus.i_jump = 1'b0; hz(1'b1, 7, 1, 7);
      cyc("loaduse_rt", S_RUN, C_STALL, 5, 2);
      hz(1'b0, 3, 1, 2); bus.i_halt_req = 1'b1;
      cyc("halt_req_run", S_RUN, C_RUN, 6, 3);
      bus.i_halt_req = 1'b0;
      cyc("paused_idle", S_IDLE, C_OFF, 7, 3);
      bus.i_start = 1'b1;
      cyc("resume_start", S_IDLE, C_OFF, 7, 3);
      bus.i_start = 1'b0; bus.i_halt_instr = 1'b1; hz(1'b1, 5, 5, 2);
      cyc("halt_blocked_by_lu", S_RUN, C_STALL, 7, 3);
      hz(1'b0, 3, 1, 2); bus.i_halt_req = 1'b1;
      cyc("halt_instr_prio", S_RUN, C_RUN, 8, 4);
      bus.i_halt_instr = 1'b0; bus.i_start = 1'b1;
      cyc("drain1", S_DRAIN, C_DRAIN, 9, 4);
      bus.i_halt_req = 1'b0; bus.i_start = 1'b0; bus.i_step = 1'b1;
      cyc("drain2", S_DRAIN, C_DRAIN, 10, 4);
      bus.i_step = 1'b0;
      cyc("drain3", S_DRAIN, C_DRAIN, 11, 4);
      cyc("drain4", S_DRAIN, C_DRAIN, 12, 4);
      bus.i_start = 1'b1;
      cyc("done_start_ign", S_DONE, C_DONE, 13, 4);
      bus.i_start = 1'b0; bus.i_step = 1'b1;
      cyc("done_step_ign", S_DONE, C_DONE, 13, 4);
      bus.i_step = 1'b0; rst = 1'b1;
      cyc("done_rst_edge", S_DONE, C_DONE, 13, 4);
      rst = 1'b0;
      cyc("after_rst", S_IDLE, C_OFF, 0, 0);
      bus.i_step = 1'b1;
      cyc("step_req", S_IDLE, C_OFF, 0, 0);
      bus.i_step = 1'b0;
      cyc("step_active", S_STEP, C_RUN, 0, 0);
      bus.i_start = 1'b1; bus.i_step = 1'b1;
      cyc("step_back_idle", S_IDLE, C_OFF, 1, 0);
      bus.i_start = 1'b0; bus.i_step = 1'b0;
      cyc("start_wins", S_RUN, C_RUN, 1, 0);
      bus.i_halt_req = 1'b1;
      cyc("pause2", S_RUN, C_RUN, 2, 0);
      bus.i_halt_req = 1'b0; bus.i_step = 1'b1;
      cyc("idle_step2", S_IDLE, C_OFF, 3, 0);
      bus.i_step = 1'b0; bus.i_halt_instr = 1'b1; hz(1'b1, 5, 5, 2);
      cyc("step_stalled", S_STEP, C_STALL, 3, 0);
      bus.i_halt_instr = 1'b0; hz(1'b0, 3, 1, 2); bus.i_step = 1'b1;
      cyc("step_consumed", S_IDLE, C_OFF, 4, 1);
      bus.i_step = 1'b0; bus.i_halt_instr = 1'b1;
      cyc("step_halt", S_STEP, C_RUN, 4, 1);
      bus.i_halt_instr = 1'b0;
      cyc("step_drain1", S_DRAIN, C_DRAIN, 5, 1);
      rst = 1'b1;
      cyc("drain_rst_edge", S_DRAIN, C_DRAIN, 6, 1);
      rst = 1'b0; hz(1'b1, 5, 5, 2);
      cyc("idle_after_drain_rst", S_IDLE, C_OFF, 0, 0);
      hz(1'b0, 3, 1, 2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
      end
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
